// File: rtl/xulie_pkg.sv
// xulie_pkg: shared FSM state encoding and default pattern for the xulie generator/detector family.
package xulie_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] XULIE_PAT_1110 = 4'b1110;

endpackage

// File: rtl/xulie_shreg.sv
// xulie_shreg: parallel-load, shift-left register with serial MSB output.
module xulie_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_d, sr_q;

    always_comb sr_d = load ? din : shift ? {sr_q[W-2:0], 1'b0} : clr ? '0 : sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/xulie_gen.sv
// xulie_gen: serial pattern generator; sends PATTERN MSB-first max(Rep,1) times, then pulses Done.
module xulie_gen
    import xulie_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = XULIE_PAT_1110,
    parameter int               CNT_W   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [CNT_W-1:0] Rep,
    input  logic             Abort,
    output logic             Dout,
    output logic             Dvalid,
    output logic             Busy,
    output logic             Done
);

    localparam int            BW   = $clog2(PAT_W);
    localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);

    logic [1:0]       state_d, state_q;
    logic [BW-1:0]    bit_d, bit_q;
    logic [CNT_W-1:0] rep_d, rep_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             load, shift, clr;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        load    = 1'b0;
        shift   = 1'b0;
        clr     = 1'b0;
        if (state_q == S_IDLE) begin
            if (Start && !Abort) begin
                state_d = S_SEND;
                bit_d   = '0;
                rep_d   = (Rep == '0) ? CNT_W'(1) : Rep;
                load    = 1'b1;
            end
        end else if (state_q == S_SEND) begin
            if (Abort) begin
                state_d = S_IDLE;
                bit_d   = '0;
                rep_d   = '0;
                clr     = 1'b1;
            end else if (bit_q == LAST) begin
                bit_d = '0;
                // reload keeps repetitions back-to-back with no idle bit between them
                if (rep_q > CNT_W'(1)) begin
                    rep_d = rep_q - CNT_W'(1);
                    load  = 1'b1;
                end else begin
                    state_d = S_DONE;
                    rep_d   = '0;
                    clr     = 1'b1;
                end
            end else begin
                bit_d = bit_q + BW'(1);
                shift = 1'b1;
            end
        end else begin
            state_d = S_IDLE;
        end
        busy_d = (state_d == S_SEND);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            rep_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    xulie_shreg #(.W(PAT_W)) u_shreg (
        .clk  (Clk),
        .rst_n(Reset),
        .load (load),
        .shift(shift),
        .clr  (clr),
        .din  (PATTERN),
        .msb  (Dout)
    );

    assign Dvalid = busy_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_xulie_gen.sv
// tb_xulie_gen: directed checks of xulie_gen with a bench-side "1110" loopback detector.
module tb_xulie_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rep = 4'd0;
    logic       abort = 1'b0;
    logic       dout, dvalid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int det_cnt = 0;
    int det0;
    logic [3:0] hist = 4'd0;

    logic [63:0] seq, dvm;
    int dvn, bn, dn, da;

    xulie_gen dut (
        .Clk   (clk),
        .Reset (rst_n),
        .Start (start),
        .Rep   (rep),
        .Abort (abort),
        .Dout  (dout),
        .Dvalid(dvalid),
        .Busy  (busy),
        .Done  (done)
    );

    always #5 clk = ~clk;

    // models the detector fed straight from Dout
    always @(posedge clk) begin
        hist <= {hist[2:0], dout};
        if ({hist[2:0], dout} == 4'b1110) det_cnt <= det_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic watch(input int n, output logic [63:0] s, output logic [63:0] m,
                         output int v, output int b, output int d, output int at);
        s = '0; m = '0; v = 0; b = 0; d = 0; at = -1;
        for (int i = 0; i < n; i++) begin
            if (dvalid) begin
                s = {s[62:0], dout};
                m[i] = 1'b1;
                v++;
            end
            if (busy) b++;
            if (done) begin
                d++;
                at = i;
            end
            tick();
        end
    endtask

    task automatic outs_zero(input string tag);
        check(tag, 64'({dout, dvalid, busy, done}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #2;
        outs_zero("reset_outs");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        outs_zero("idle_outs");

        // Rep=1
        start = 1'b1; rep = 4'd1;
        tick();
        start = 1'b0;
        check("r1_first", 64'({dout, dvalid, busy, done}), 64'b1110);
        watch(8, seq, dvm, dvn, bn, dn, da);
        check("r1_seq", seq, 64'hE);
        check("r1_dvn", 64'(dvn), 64'd4);
        check("r1_busy", 64'(bn), 64'd4);
        check("r1_done_n", 64'(dn), 64'd1);
        check("r1_done_at", 64'(da), 64'd4);

        // Rep=3, Rep changed after acceptance must be ignored
        det0 = det_cnt;
        start = 1'b1; rep = 4'd3;
        tick();
        start = 1'b0; rep = 4'd7;
        watch(16, seq, dvm, dvn, bn, dn, da);
        check("r3_seq", seq, 64'hEEE);
        check("r3_dvn", 64'(dvn), 64'd12);
        check("r3_done_n", 64'(dn), 64'd1);
        check("r3_done_at", 64'(da), 64'd12);
        check("r3_loop_det", 64'(det_cnt - det0), 64'd3);

        // Rep=0 behaves as Rep=1
        start = 1'b1; rep = 4'd0;
        tick();
        start = 1'b0;
        watch(8, seq, dvm, dvn, bn, dn, da);
        check("r0_seq", seq, 64'hE);
        check("r0_dvn", 64'(dvn), 64'd4);
        check("r0_done_at", 64'(da), 64'd4);

        // Abort during the 2nd bit of Rep=2
        det0 = det_cnt;
        start = 1'b1; rep = 4'd2;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        outs_zero("abort_outs");
        start = 1'b1; rep = 4'd1;
        tick();
        start = 1'b0;
        check("abort_restart_busy", 64'(busy), 64'd1);
        watch(8, seq, dvm, dvn, bn, dn, da);
        check("abort_restart_done", 64'(dn), 64'd1);
        check("abort_loop_det", 64'(det_cnt - det0), 64'd1);

        // Start and Abort together in IDLE: Abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        outs_zero("start_abort_idle");

        // Start held high: one transmission per IDLE visit, 2-cycle gap
        start = 1'b1; rep = 4'd1;
        watch(20, seq, dvm, dvn, bn, dn, da);
        start = 1'b0;
        check("held_dvmap", dvm, 64'h9E79E);
        check("held_done_n", 64'(dn), 64'd3);
        watch(6, seq, dvm, dvn, bn, dn, da);
        check("held_drain_dvn", 64'(dvn), 64'd3);
        check("held_drain_done", 64'(dn), 64'd1);

        // Loopback, Rep=2: two detections
        det0 = det_cnt;
        start = 1'b1; rep = 4'd2;
        tick();
        start = 1'b0;
        watch(12, seq, dvm, dvn, bn, dn, da);
        check("loop_r2_seq", seq, 64'hEE);
        check("loop_r2_det", 64'(det_cnt - det0), 64'd2);

        // Async reset at bit 3 of Rep=2
        start = 1'b1; rep = 4'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        outs_zero("async_reset_outs");
        @(negedge clk);
        rst_n = 1'b1;
        watch(8, seq, dvm, dvn, bn, dn, da);
        check("post_reset_dvn", 64'(dvn), 64'd0);
        check("post_reset_done", 64'(dn), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
